// File: rtl/rail_sequence_monitor.sv
// ---------------------------------------------------------------------------
// rail_sequence_monitor
//
// Power-good monitor for NUM_RAILS regulator rails. Each raw rail-good input
// is brought into the i_clk domain with a 2-FF synchroniser and then filtered
// by a per-rail debouncer. Once every filtered rail is good, the block waits
// STARTUP_DELAY cycles before asserting o_allGood. A rail lost while in GOOD
// latches a fault together with the mask of the rails that were low.
//
// Optional feature (macro RAIL_AUTO_RETRY_EN):
//   defined     - FAULT returns to WAIT by itself after RETRY_DELAY cycles
//   not defined - FAULT is held until i_fault_clear
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_rails        raw rail-good inputs (asynchronous to i_clk)
//   i_enable       monitor enable; low forces IDLE (except from FAULT)
//   i_fault_clear  single-cycle pulse that clears a latched fault
//   o_allGood      registered, high only in GOOD
//   o_fault        registered, high only in FAULT
//   o_faultRails   rails that were low when the fault was taken (sticky)
//   o_state        IDLE=0, WAIT=1, DELAY=2, GOOD=3, FAULT=4
// ---------------------------------------------------------------------------
module rail_sequence_monitor #(
  parameter int          NUM_RAILS       = 5,
  parameter int          CNT_W           = 32,
  parameter int unsigned STARTUP_DELAY   = 32'd1000,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int unsigned RETRY_DELAY     = 32'd100000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_RAILS-1:0] i_rails,
  input  logic                 i_enable,
  input  logic                 i_fault_clear,
  output logic                 o_allGood,
  output logic                 o_fault,
  output logic [NUM_RAILS-1:0] o_faultRails,
  output logic [2:0]           o_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_DELAY = 3'd2,
    ST_GOOD  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  logic [NUM_RAILS-1:0] sync1_q, sync2_q;
  logic [NUM_RAILS-1:0] filt_q, filt_d;
  logic                 all_ok;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     dly_cnt_q, dly_cnt_d;
  logic [NUM_RAILS-1:0] fault_rails_q, fault_rails_d;
  logic                 all_good_q, all_good_d;
  logic                 fault_q, fault_d;

  // Two-stage synchroniser on every raw rail input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_rails;
      sync2_q <= sync1_q;
    end
  end

  // The filtered value flips only after the synchronised value has disagreed
  // with it on DEBOUNCE_CYCLES+1 consecutive edges: the counter climbs to
  // DEBOUNCE_CYCLES, and the next disagreeing edge performs the flip. Any
  // agreeing edge restarts the count.
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_db_bypass
      always_comb filt_d = sync2_q;
    end else begin : g_db
      localparam int DbW = $clog2(DEBOUNCE_CYCLES + 1);
      for (genvar r = 0; r < NUM_RAILS; r++) begin : g_rail
        logic [DbW-1:0] cnt_q, cnt_d;
        logic           bit_d;

        always_comb begin
          cnt_d = '0;
          bit_d = filt_q[r];
          if (sync2_q[r] != filt_q[r]) begin
            if (cnt_q == DbW'(DEBOUNCE_CYCLES)) begin
              bit_d = sync2_q[r];
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) cnt_q <= '0;
          else          cnt_q <= cnt_d;
        end

        assign filt_d[r] = bit_d;
      end
    end
  endgenerate

  assign all_ok = &filt_q;

`ifdef RAIL_AUTO_RETRY_EN
  logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;
  logic             retry_done;

  assign retry_done = (RETRY_DELAY == 0) ||
                      (retry_cnt_q == CNT_W'(RETRY_DELAY - 1));

  // Retry dwell counter runs only while sitting in FAULT.
  always_comb begin
    retry_cnt_d = '0;
    if (state_q == ST_FAULT && retry_cnt_q != '1) begin
      retry_cnt_d = retry_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) retry_cnt_q <= '0;
    else          retry_cnt_q <= retry_cnt_d;
  end
`endif

  // Next-state logic. Commanded shutdown (i_enable low) takes priority over
  // rail loss, so disabling the monitor never records a fault.
  always_comb begin
    state_d       = state_q;
    dly_cnt_d     = dly_cnt_q;
    fault_rails_d = fault_rails_q;

    unique case (state_q)
      ST_IDLE: begin
        dly_cnt_d = '0;
        if (i_enable) state_d = ST_WAIT;
      end

      ST_WAIT: begin
        dly_cnt_d = '0;
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (all_ok) begin
          state_d = (STARTUP_DELAY == 0) ? ST_GOOD : ST_DELAY;
        end
      end

      ST_DELAY: begin
        if (!i_enable) begin
          state_d   = ST_IDLE;
          dly_cnt_d = '0;
        end else if (!all_ok) begin
          state_d   = ST_WAIT;
          dly_cnt_d = '0;
        end else if (dly_cnt_q == CNT_W'(STARTUP_DELAY - 1)) begin
          state_d   = ST_GOOD;
          dly_cnt_d = '0;
        end else if (dly_cnt_q != '1) begin
          dly_cnt_d = dly_cnt_q + 1'b1;
        end
      end

      ST_GOOD: begin
        dly_cnt_d = '0;
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (!all_ok) begin
          state_d       = ST_FAULT;
          fault_rails_d = ~filt_q;
        end
      end

      ST_FAULT: begin
        dly_cnt_d = '0;
        if (i_fault_clear) begin
          state_d       = i_enable ? ST_WAIT : ST_IDLE;
          fault_rails_d = '0;
        end
`ifdef RAIL_AUTO_RETRY_EN
        else if (retry_done) begin
          state_d = ST_WAIT;
        end
`endif
      end

      default: begin
        state_d   = ST_IDLE;
        dly_cnt_d = '0;
      end
    endcase

    // A mask left over from an automatic retry is dropped on reaching GOOD.
    if (state_d == ST_GOOD) fault_rails_d = '0;
  end

  always_comb begin
    all_good_d = (state_d == ST_GOOD);
    fault_d    = (state_d == ST_FAULT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      filt_q        <= '0;
      state_q       <= ST_IDLE;
      dly_cnt_q     <= '0;
      fault_rails_q <= '0;
      all_good_q    <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      filt_q        <= filt_d;
      state_q       <= state_d;
      dly_cnt_q     <= dly_cnt_d;
      fault_rails_q <= fault_rails_d;
      all_good_q    <= all_good_d;
      fault_q       <= fault_d;
    end
  end

  assign o_allGood    = all_good_q;
  assign o_fault      = fault_q;
  assign o_faultRails = fault_rails_q;
  assign o_state      = state_q;

endmodule
